param_sync_fifo: RTL and testbench

Parametrised single-clock FIFO, the next generation of our 8-bit FIFO block. Adds configurable width and depth, occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. Sits between a producer and a consumer in the same clock domain as a general-purpose rate-matching buffer.

---
 rtl/param_sync_fifo_if.sv | 35 +++
 rtl/param_sync_fifo.sv | 109 ++++++++++
 tb/tb_param_sync_fifo.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/param_sync_fifo_if.sv
// Handshake/status bundle for param_sync_fifo.
// The producer/consumer side uses master; the FIFO itself uses slave.
interface param_sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                  write_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  flush;
  logic                  clear_err;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_W:0]       count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write_en, data_in, read_en, flush, clear_err,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  write_en, data_in, read_en, flush, clear_err,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  param_sync_fifo_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_W-1:0]     wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0]     rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
  logic                  dataValid_q, dataValid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic full, empty;
  logic wrAccept, rdAccept;
  logic ovSet, unSet;

  // Status comes from the registered count only, so a same-cycle read never
  // frees room for a write and a same-cycle write never feeds a read.
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

  assign wrAccept = bus.write_en && !full  && !bus.flush;
  assign rdAccept = bus.read_en  && !empty && !bus.flush;
  assign ovSet    = bus.write_en && full  && !bus.flush;
  assign unSet    = bus.read_en  && empty && !bus.flush;

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    dataOut_d   = dataOut_q;
    dataValid_d = 1'b0;

    if (bus.flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (wrAccept) begin
        wrPtr_d = wrPtr_q + 1'b1;
      end
      if (rdAccept) begin
        rdPtr_d     = rdPtr_q + 1'b1;
        dataOut_d   = mem[rdPtr_q];
        dataValid_d = 1'b1;
      end
      case ({wrAccept, rdAccept})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // A new error in the same cycle as clear_err keeps the flag set.
    overflow_d  = ovSet | (overflow_q  & ~bus.clear_err);
    underflow_d = unSet | (underflow_q & ~bus.clear_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      dataOut_q   <= '0;
      dataValid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      dataOut_q   <= dataOut_d;
      dataValid_q <= dataValid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset; the pointers guarantee that
  // unwritten entries are never read.
  always_ff @(posedge clk) begin
    if (wrAccept) begin
      mem[wrPtr_q] <= bus.data_in;
    end
  end

  assign bus.data_out     = dataOut_q;
  assign bus.data_valid   = dataValid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (int'(count_q) >= AF_LEVEL);
  assign bus.almost_empty = (int'(count_q) <= AE_LEVEL);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: a queue model predicts status and
// a scoreboard of expected read data is checked whenever data_valid pulses.
module tb_param_sync_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  param_sync_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .AF_LEVEL  (AF),
    .AE_LEVEL  (AE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] modelQ [$];
  logic [DW-1:0] expQ   [$];
  logic          ovM    = 1'b0;
  logic          unM    = 1'b0;
  logic          validM = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkStatus(input string tag);
    int n;
    n = modelQ.size();
    checkOutput({tag, "/count"},        32'(bus.count),        32'(n));
    checkOutput({tag, "/full"},         32'(bus.full),         32'(n == DEPTH));
    checkOutput({tag, "/empty"},        32'(bus.empty),        32'(n == 0));
    checkOutput({tag, "/almost_full"},  32'(bus.almost_full),  32'(n >= AF));
    checkOutput({tag, "/almost_empty"}, 32'(bus.almost_empty), 32'(n <= AE));
    checkOutput({tag, "/overflow"},     32'(bus.overflow),     32'(ovM));
    checkOutput({tag, "/underflow"},    32'(bus.underflow),    32'(unM));
    checkOutput({tag, "/data_valid"},   32'(bus.data_valid),   32'(validM));
  endtask

  // One clock of stimulus: predict the outcome, push expected read data,
  // then check status just after the edge.
  task automatic applyStimulus(input string tag, input logic we, input logic [DW-1:0] din,
                               input logic re, input logic fl, input logic ce);
    int n;
    logic wrOk, rdOk;
    bus.write_en  = we;
    bus.data_in   = din;
    bus.read_en   = re;
    bus.flush     = fl;
    bus.clear_err = ce;
    n    = modelQ.size();
    wrOk = we && (n < DEPTH) && !fl;
    rdOk = re && (n != 0) && !fl;
    if (we && (n == DEPTH) && !fl) ovM = 1'b1;
    else if (ce)                   ovM = 1'b0;
    if (re && (n == 0) && !fl)     unM = 1'b1;
    else if (ce)                   unM = 1'b0;
    validM = rdOk;
    if (fl) begin
      modelQ.delete();
    end else begin
      if (rdOk) expQ.push_back(modelQ.pop_front());
      if (wrOk) modelQ.push_back(din);
    end
    @(posedge clk);
    #1;
    bus.write_en  = 1'b0;
    bus.read_en   = 1'b0;
    bus.flush     = 1'b0;
    bus.clear_err = 1'b0;
    checkStatus(tag);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.data_valid) begin
      if (expQ.size() == 0) checkOutput("spurious_valid", 32'(bus.data_valid), 32'(0));
      else                  checkOutput("rdata", 32'(bus.data_out), 32'(expQ.pop_front()));
    end
  end

  initial begin
    bus.write_en  = 1'b0;
    bus.data_in   = '0;
    bus.read_en   = 1'b0;
    bus.flush     = 1'b0;
    bus.clear_err = 1'b0;

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst/data_out", 32'(bus.data_out), 32'(0));
    checkStatus("rst");
    rst_n = 1'b1;

    $display("[TB] fill and overflow");
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus("fill", 1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      if (i == AF - 1) checkOutput("fill/af_before", 32'(bus.almost_full), 32'(0));
      if (i == AF)     checkOutput("fill/af_at",     32'(bus.almost_full), 32'(1));
    end
    checkOutput("fill/count16", 32'(bus.count), 32'(16));
    checkOutput("fill/full",    32'(bus.full),  32'(1));
    applyStimulus("ovf", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf/overflow", 32'(bus.overflow), 32'(1));
    checkOutput("ovf/count",    32'(bus.count),    32'(16));

    $display("[TB] drain and wrap");
    for (int i = 0; i < DEPTH; i++) applyStimulus("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus("drain_idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("drain/empty",     32'(bus.empty),     32'(1));
    checkOutput("drain/hold",      32'(bus.data_out),  32'(8'h10));
    checkOutput("drain/underflow", 32'(bus.underflow), 32'(0));
    applyStimulus("wrap_wr", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    applyStimulus("wrap_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("wrap/data", 32'(bus.data_out), 32'(8'hA5));

    $display("[TB] simultaneous read and write");
    for (int i = 0; i < 5; i++) applyStimulus("sim_fill", 1'b1, DW'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("sim_both", 1'b1, DW'(8'h60 + i), 1'b1, 1'b0, 1'b0);
      checkOutput("sim/count5", 32'(bus.count), 32'(5));
    end
    for (int i = 0; i < 5; i++) applyStimulus("sim_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus("sim_idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus("sim_empty_both", 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    checkOutput("sim0/count",     32'(bus.count),      32'(1));
    checkOutput("sim0/underflow", 32'(bus.underflow),  32'(1));
    checkOutput("sim0/valid",     32'(bus.data_valid), 32'(0));

    $display("[TB] flush");
    applyStimulus("clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr/overflow", 32'(bus.overflow), 32'(0));
    for (int i = 0; i < 8; i++) applyStimulus("fl_fill", 1'b1, DW'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    checkOutput("fl/count9", 32'(bus.count), 32'(9));
    applyStimulus("flush", 1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    checkOutput("flush/count",    32'(bus.count),      32'(0));
    checkOutput("flush/empty",    32'(bus.empty),      32'(1));
    checkOutput("flush/overflow", 32'(bus.overflow),   32'(0));
    checkOutput("flush/valid",    32'(bus.data_valid), 32'(0));
    checkOutput("flush/hold",     32'(bus.data_out),   32'(8'h63));
    applyStimulus("fl_wr", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    applyStimulus("fl_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("flush/readback", 32'(bus.data_out), 32'(8'h3C));

    $display("[TB] error clear");
    for (int i = 0; i < DEPTH; i++) applyStimulus("ec_fill", 1'b1, DW'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus("ec_ovf", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    checkOutput("ec/set", 32'(bus.overflow), 32'(1));
    applyStimulus("ec_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("ec/clr", 32'(bus.overflow), 32'(0));
    applyStimulus("ec_setwins", 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
    checkOutput("ec/setwins", 32'(bus.overflow), 32'(1));

    $display("[TB] reset mid-operation");
    applyStimulus("mr_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    bus.read_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    bus.read_en = 1'b0;
    modelQ.delete();
    expQ.delete();
    ovM    = 1'b0;
    unM    = 1'b0;
    validM = 1'b0;
    checkOutput("mr/data_out", 32'(bus.data_out), 32'(0));
    checkStatus("mr");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus("mr_idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("mr/idle_valid", 32'(bus.data_valid), 32'(0));

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
